i2c_slave_byte_ctl: RTL and testbench

I2C_SLAVE_BYTE_CTL -- requirements
Module: i2c_slave_byte_ctl

---
 rtl/i2c_slave_byte_ctl_pkg.sv | 78 +++++++
 rtl/i2c_slave_byte_ctl_glitch_filter.sv | 37 +++
 rtl/i2c_slave_byte_ctl.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_slave_byte_ctl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_byte_ctl_pkg.sv
// Shared I2C definitions: slave FSM states, ACK/NAK line levels, master
// command codes and the slave controller's registered context.
package i2c_slave_byte_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX        = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX        = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Line level seen or driven during the ninth bit.
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  // Command codes used by the companion master controller.
  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_START  = 3'd1,
    CMD_WRITE  = 3'd2,
    CMD_READ   = 3'd3,
    CMD_STOP   = 3'd4,
    CMD_RSTART = 3'd5
  } cmd_t;

  // Everything the slave controller registers besides its state.
  typedef struct packed {
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       tx_wait;
    logic       tx_got;
    logic       sda_oen;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       tx_underrun;
    logic       addr_match;
    logic       rw;
    logic       stop;
    logic       busy;
    logic       scl_q;
    logic       sda_q;
  } ctl_t;

  // Idle bus: both lines remembered high, SDA released, no pulses.
  localparam ctl_t CTL_RESET = '{
    bit_cnt:     4'd0,
    shift:       8'h00,
    tx_shift:    8'hFF,
    tx_buf:      8'h00,
    tx_wait:     1'b0,
    tx_got:      1'b0,
    sda_oen:     1'b1,
    rx_data:     8'h00,
    rx_valid:    1'b0,
    tx_req:      1'b0,
    tx_underrun: 1'b0,
    addr_match:  1'b0,
    rw:          1'b0,
    stop:        1'b0,
    busy:        1'b0,
    scl_q:       1'b1,
    sda_q:       1'b1
  };

  // True when the 7-bit address field of a received address byte is ours.
  function automatic logic addr_hit(input logic [7:0] addr_byte,
                                    input logic [6:0] own);
    return addr_byte[7:1] == own;
  endfunction

endpackage

// File: rtl/i2c_slave_byte_ctl_glitch_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised input once it has held a new level for
// dfsr+1 consecutive clocks. Everything resets to 1 (idle bus).
module i2c_glitch_filter #(
  parameter int FILT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad,
  input  logic [FILT_W-1:0] dfsr,
  output logic              filt
);

  logic [1:0]        sync;
  logic [FILT_W-1:0] cnt;

  // Synchronise the pad, then count how long it has disagreed with the output.
  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], pad};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == dfsr) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_byte_ctl.sv
// I2C byte-level slave: filters the bus, detects START/STOP, receives the
// address, then receives or transmits bytes with ACK handling. SCL is never
// driven (no clock stretching); SDA is open-drain through o_sda_oen.
module i2c_slave_byte_ctl
  import i2c_slave_byte_ctl_pkg::*;
#(
  parameter int FILT_W = 6
) (
  input  logic              i_sysclk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [6:0]        i_own_addr,
  input  logic [FILT_W-1:0] i_dfsr,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_sda_oen,
  input  logic [7:0]        i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_req,
  output logic              o_tx_underrun,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_valid,
  output logic              o_addr_match,
  output logic              o_rw,
  output logic              o_stop,
  output logic              o_busy
);

  state_t     state, state_next;
  ctl_t       r, rn;
  logic       scl_f, sda_f;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic [7:0] shift_in;
  logic       tx_avail;
  logic [7:0] tx_byte;
  logic       do_load;

  i2c_glitch_filter #(.FILT_W(FILT_W)) u_scl_filt (
    .clk   (i_sysclk),
    .rst_n (i_reset_n),
    .pad   (i_scl),
    .dfsr  (i_dfsr),
    .filt  (scl_f)
  );

  i2c_glitch_filter #(.FILT_W(FILT_W)) u_sda_filt (
    .clk   (i_sysclk),
    .rst_n (i_reset_n),
    .pad   (i_sda),
    .dfsr  (i_dfsr),
    .filt  (sda_f)
  );

  // Bus strobes from the filtered lines. START/STOP require SCL high both
  // before and after the SDA edge so simultaneous filter updates never fake one.
  assign scl_rise  = scl_f & ~r.scl_q;
  assign scl_fall  = ~scl_f & r.scl_q;
  assign sda_rise  = sda_f & ~r.sda_q;
  assign sda_fall  = ~sda_f & r.sda_q;
  assign start_det = sda_fall & scl_f & r.scl_q;
  assign stop_det  = sda_rise & scl_f & r.scl_q;
  assign shift_in  = {r.shift[6:0], sda_f};

  // Byte to send next: the buffered one, a same-cycle valid, or 0xFF on underrun.
  assign tx_avail = r.tx_got | (r.tx_wait & i_tx_valid);
  assign tx_byte  = r.tx_got ? r.tx_buf : (tx_avail ? i_tx_data : 8'hFF);

  // State register and controller context.
  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      r     <= CTL_RESET;
    end else begin
      state <= state_next;
      r     <= rn;
    end
  end

  // Next-state and next-context logic; START/STOP/disable override bit handling.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    state_next     = state;
    rn             = r;
    do_load        = 1'b0;
    rn.rx_valid    = 1'b0;
    rn.tx_req      = 1'b0;
    rn.tx_underrun = 1'b0;
    rn.addr_match  = 1'b0;
    rn.stop        = 1'b0;
    rn.scl_q       = scl_f;
    rn.sda_q       = sda_f;

    if (r.tx_wait && !r.tx_got && i_tx_valid) begin
      rn.tx_got = 1'b1;
      rn.tx_buf = i_tx_data;
    end

    if (stop_det) begin
      state_next = ST_IDLE;
      rn.sda_oen = 1'b1;
      rn.busy    = 1'b0;
      rn.stop    = 1'b1;
      rn.tx_wait = 1'b0;
    end else if (start_det) begin
      state_next = i_enable ? ST_ADDR : ST_IDLE;
      rn.sda_oen = 1'b1;
      rn.busy    = 1'b1;
      rn.bit_cnt = 4'd0;
      rn.tx_wait = 1'b0;
    end else if (!i_enable) begin
      state_next = ST_IDLE;
      rn.sda_oen = 1'b1;
      rn.tx_wait = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            rn.shift   = shift_in;
            rn.bit_cnt = r.bit_cnt + 4'd1;
            if (r.bit_cnt == 4'd7) begin
              if (addr_hit(shift_in, i_own_addr)) begin
                rn.addr_match = 1'b1;
                rn.rw         = shift_in[0];
                state_next    = ST_ADDR_ACK;
              end else begin
                state_next = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_RX: begin
          if (scl_rise) begin
            rn.shift   = shift_in;
            rn.bit_cnt = r.bit_cnt + 4'd1;
            if (r.bit_cnt == 4'd7) begin
              rn.rx_data  = shift_in;
              rn.rx_valid = 1'b1;
              state_next  = ST_RX_ACK;
            end
          end
        end

        ST_TX: begin
          if (scl_rise) begin
            rn.bit_cnt = r.bit_cnt + 4'd1;
            if (r.bit_cnt == 4'd7) state_next = ST_TX_ACK;
          end else if (scl_fall) begin
            rn.sda_oen  = r.tx_shift[7];
            rn.tx_shift = {r.tx_shift[6:0], 1'b1};
          end
        end

        // Ninth bit: drive ACK (or release when the master acknowledges),
        // then decide where the next byte goes on the following fall.
        ST_ADDR_ACK, ST_RX_ACK, ST_TX_ACK: begin
          if (scl_fall && r.bit_cnt == 4'd8) begin
            rn.sda_oen = (state == ST_TX_ACK) ? I2C_NAK : I2C_ACK;
          end else if (scl_rise && r.bit_cnt == 4'd8) begin
            rn.bit_cnt = 4'd0;
            if (state == ST_TX_ACK && sda_f == I2C_NAK) begin
              state_next = ST_WAIT_STOP;
            end else if (state == ST_TX_ACK || (state == ST_ADDR_ACK && r.rw)) begin
              rn.tx_req  = 1'b1;
              rn.tx_wait = 1'b1;
              rn.tx_got  = 1'b0;
            end
          end else if (scl_fall && r.bit_cnt == 4'd0) begin
            if (state == ST_RX_ACK || (state == ST_ADDR_ACK && !r.rw)) begin
              rn.sda_oen = 1'b1;
              state_next = ST_RX;
            end else begin
              do_load = 1'b1;
            end
          end
        end

        default: ;
      endcase

      if (do_load) begin
        rn.sda_oen     = tx_byte[7];
        rn.tx_shift    = {tx_byte[6:0], 1'b1};
        rn.tx_underrun = ~tx_avail;
        rn.tx_wait     = 1'b0;
        rn.tx_got      = 1'b0;
        state_next     = ST_TX;
      end
    end
  end

  assign o_sda_oen     = r.sda_oen;
  assign o_tx_req      = r.tx_req;
  assign o_tx_underrun = r.tx_underrun;
  assign o_rx_data     = r.rx_data;
  assign o_rx_valid    = r.rx_valid;
  assign o_addr_match  = r.addr_match;
  assign o_rw          = r.rw;
  assign o_stop        = r.stop;
  assign o_busy        = r.busy;

endmodule

// File: tb/tb_i2c_slave_byte_ctl.sv
// Directed bench for i2c_slave_byte_ctl: a bit-banged master on a wired-AND
// SDA line, a table of write transactions, and hand-written sequences for
// reads, underrun, repeated START, enable drop, reset and glitch filtering.
module tb_i2c_slave_byte_ctl;
  import i2c_slave_byte_ctl_pkg::*;

  localparam int FILT_W = 6;
  localparam int Q      = 10;  // quarter bit period in clocks

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [6:0]        own_addr;
  logic [FILT_W-1:0] dfsr;
  logic              scl_drv, sda_drv;
  logic              sda_line;
  logic              sda_oen;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_req, tx_underrun;
  logic [7:0]        rx_data;
  logic              rx_valid, addr_match, rw, stop, busy;

  always #5 clk = ~clk;

  assign sda_line = sda_drv & sda_oen;

  i2c_slave_byte_ctl #(.FILT_W(FILT_W)) dut (
    .i_sysclk      (clk),
    .i_reset_n     (rst_n),
    .i_enable      (enable),
    .i_own_addr    (own_addr),
    .i_dfsr        (dfsr),
    .i_scl         (scl_drv),
    .i_sda         (sda_line),
    .o_sda_oen     (sda_oen),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_req      (tx_req),
    .o_tx_underrun (tx_underrun),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_addr_match  (addr_match),
    .o_rw          (rw),
    .o_stop        (stop),
    .o_busy        (busy)
  );

  // Pulse and activity counters, sampled on the falling edge.
  int         n_rx = 0, n_txreq = 0, n_under = 0, n_match = 0, n_stop = 0, n_oen_low = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx    <= n_rx + 1;
      last_rx <= rx_data;
    end
    if (tx_req)      n_txreq   <= n_txreq + 1;
    if (tx_underrun) n_under   <= n_under + 1;
    if (addr_match)  n_match   <= n_match + 1;
    if (stop)        n_stop    <= n_stop + 1;
    if (!sda_oen)    n_oen_low <= n_oen_low + 1;
  end

  // Transmit-byte responder: answers each o_tx_req with one valid cycle.
  logic [7:0] tx_bytes [4];
  int         tx_base  = 0;
  logic       tx_en    = 1'b0;
  int         resp_cnt = 0;

  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        if (tx_en) begin
          tx_data  = tx_bytes[(resp_cnt - tx_base) & 3];
          tx_valid = 1'b1;
        end
        resp_cnt++;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus primitives; each leaves SCL low except stop().
  task automatic bus_start();
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b0;
  endtask

  task automatic bus_rstart();
    tick(Q); sda_drv = 1'b1;
    tick(Q); scl_drv = 1'b1;
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl_drv = 1'b1;
    tick(Q); sda_drv = 1'b1;
    tick(2 * Q);
  endtask

  task automatic bit_xfer(input logic b, output logic line);
    tick(Q); sda_drv = b;
    tick(Q); scl_drv = 1'b1;
    tick(Q); line = sda_line;
    tick(Q); scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, b);
      d[i] = b;
    end
    bit_xfer(mack, b);
  endtask

  typedef struct {
    logic [6:0] own;
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_rx;
    logic [7:0] exp_data;
    int         exp_match;
    logic       exp_quiet;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic       a, a2;
    logic [7:0] d;
    int         b_rx, b_req, b_under, b_match, b_stop, b_low;

    vecs[0] = '{7'h50, 8'hA0, 8'h3C, 1'b0, 1, 8'h3C, 1, 1'b0};
    vecs[1] = '{7'h50, 8'hA2, 8'h3C, 1'b1, 0, 8'h00, 0, 1'b1};
    vecs[2] = '{7'h7F, 8'hFE, 8'h00, 1'b0, 1, 8'h00, 1, 1'b0};
    vecs[3] = '{7'h00, 8'h00, 8'hFF, 1'b0, 1, 8'hFF, 1, 1'b0};
    vecs[4] = '{7'h2A, 8'h54, 8'hA5, 1'b0, 1, 8'hA5, 1, 1'b0};
    vecs[5] = '{7'h2B, 8'h54, 8'h5A, 1'b1, 0, 8'h00, 0, 1'b1};

    rst_n    = 1'b0;
    enable   = 1'b1;
    own_addr = 7'h50;
    dfsr     = 6'd2;
    scl_drv  = 1'b1;
    sda_drv  = 1'b1;
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;
    tick(4);

    check("reset_oen", sda_oen, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rw", rw, 1'b0);
    check("reset_pulses", {rx_valid, tx_req, tx_underrun, addr_match, stop}, 5'b0);
    check("reset_state", dut.state, ST_IDLE);

    rst_n = 1'b1;
    tick(10);

    // Write transactions from the table.
    for (int i = 0; i < 6; i++) begin
      own_addr = vecs[i].own;
      tick(5);
      b_rx = n_rx; b_match = n_match; b_stop = n_stop; b_low = n_oen_low;
      bus_start();
      write_byte(vecs[i].addr_byte, a);
      check($sformatf("v%0d_addr_ack", i), a, vecs[i].exp_ack);
      write_byte(vecs[i].data, a2);
      check($sformatf("v%0d_data_ack", i), a2, vecs[i].exp_ack);
      check($sformatf("v%0d_busy_mid", i), busy, 1'b1);
      bus_stop();
      check($sformatf("v%0d_rx_cnt", i), n_rx - b_rx, vecs[i].exp_rx);
      if (vecs[i].exp_rx != 0) check($sformatf("v%0d_rx_data", i), last_rx, vecs[i].exp_data);
      check($sformatf("v%0d_match_cnt", i), n_match - b_match, vecs[i].exp_match);
      check($sformatf("v%0d_stop_cnt", i), n_stop - b_stop, 1);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      check($sformatf("v%0d_quiet", i), n_oen_low == b_low, vecs[i].exp_quiet);
      check($sformatf("v%0d_rw", i), rw, 1'b0);
    end

    // Read 0x5A then 0xC3; master ACKs then NAKs.
    own_addr = 7'h50;
    tx_bytes[0] = 8'h5A; tx_bytes[1] = 8'hC3;
    tx_base = resp_cnt; tx_en = 1'b1;
    b_req = n_txreq; b_under = n_under;
    bus_start();
    write_byte(8'hA1, a);
    check("rd_addr_ack", a, 1'b0);
    read_byte(1'b0, d);
    check("rd_byte0", d, 8'h5A);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'hC3);
    check("rd_txreq_cnt", n_txreq - b_req, 2);
    check("rd_underrun_cnt", n_under - b_under, 0);
    check("rd_state", dut.state, ST_WAIT_STOP);
    check("rd_rw", rw, 1'b1);
    check("rd_oen", sda_oen, 1'b1);
    bus_stop();

    // Read with no transmit data supplied.
    tx_en = 1'b0;
    b_req = n_txreq; b_under = n_under;
    bus_start();
    write_byte(8'hA1, a);
    check("ur_addr_ack", a, 1'b0);
    read_byte(1'b1, d);
    check("ur_byte", d, 8'hFF);
    check("ur_underrun_cnt", n_under - b_under, 1);
    check("ur_txreq_cnt", n_txreq - b_req, 1);
    bus_stop();

    // Write, repeated START, then read.
    tx_bytes[0] = 8'h96; tx_base = resp_cnt; tx_en = 1'b1;
    b_rx = n_rx; b_match = n_match;
    bus_start();
    write_byte(8'hA0, a);
    check("rs_addr_ack", a, 1'b0);
    write_byte(8'h3C, a);
    check("rs_data_ack", a, 1'b0);
    check("rs_rx_cnt", n_rx - b_rx, 1);
    check("rs_rx_data", last_rx, 8'h3C);
    bus_rstart();
    write_byte(8'hA1, a);
    check("rs_raddr_ack", a, 1'b0);
    check("rs_rw", rw, 1'b1);
    check("rs_match_cnt", n_match - b_match, 2);
    read_byte(1'b1, d);
    check("rs_rd_byte", d, 8'h96);
    bus_stop();
    check("rs_busy_end", busy, 1'b0);
    tx_en = 1'b0;

    // Enable dropped while the slave is ACKing a written byte.
    bus_start();
    write_byte(8'hA0, a);
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h81 >> i) & 8'h01) != 0, a2);
    tick(Q);
    check("en_ack_driven", sda_oen, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    check("en_oen_released", sda_oen, 1'b1);
    check("en_state", dut.state, ST_IDLE);
    check("en_busy", busy, 1'b1);
    @(negedge clk);
    bit_xfer(1'b1, a2);
    enable = 1'b1;
    bus_stop();
    check("en_busy_end", busy, 1'b0);

    // Reset pulled low while the slave is ACKing a written byte.
    bus_start();
    write_byte(8'hA0, a);
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h81 >> i) & 8'h01) != 0, a2);
    tick(Q);
    check("rst_ack_driven", sda_oen, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_oen_released", sda_oen, 1'b1);
    check("rst_state", dut.state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    b_rx = n_rx; b_match = n_match; b_low = n_oen_low;
    bit_xfer(1'b1, a2);
    write_byte(8'hA0, a);
    check("rst_ignored_ack", a, 1'b1);
    check("rst_ignored_match", n_match - b_match, 0);
    check("rst_ignored_rx", n_rx - b_rx, 0);
    check("rst_ignored_quiet", n_oen_low - b_low, 0);
    check("rst_busy", busy, 1'b0);
    bus_stop();
    bus_start();
    write_byte(8'hA0, a);
    check("rst_recover_ack", a, 1'b0);
    bus_stop();

    // Glitch filtering: 3-cycle SDA glitches while SCL is high.
    dfsr = 6'd4;
    tick(20);
    b_stop = n_stop;
    sda_drv = 1'b0; tick(3); sda_drv = 1'b1; tick(20);
    check("gl4_start_busy", busy, 1'b0);
    check("gl4_start_state", dut.state, ST_IDLE);
    sda_drv = 1'b0; tick(20);
    check("gl4_real_start", busy, 1'b1);
    check("gl4_real_state", dut.state, ST_ADDR);
    sda_drv = 1'b1; tick(3); sda_drv = 1'b0; tick(20);
    check("gl4_stop_cnt", n_stop - b_stop, 0);
    check("gl4_stop_busy", busy, 1'b1);
    dfsr = 6'd1;
    tick(5);
    sda_drv = 1'b1; tick(3); sda_drv = 1'b0; tick(20);
    check("gl1_stop_cnt", n_stop - b_stop, 1);
    check("gl1_restart_busy", busy, 1'b1);
    check("gl1_restart_state", dut.state, ST_ADDR);
    sda_drv = 1'b1; tick(20);
    check("gl1_clean_stop", busy, 1'b0);
    b_stop = n_stop;
    sda_drv = 1'b0; tick(3); sda_drv = 1'b1; tick(20);
    check("gl1_start_seen", n_stop - b_stop, 1);
    check("gl1_end_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
